// File: rtl/clks_alot_half_rate_tracker.sv
// clks_alot_half_rate_tracker
// Measures the high and low half-periods of a recovered clock from single-cycle
// edge pulses, checks each against min/max bands, tracks lock-in and detects
// pauses in the recovered clock.
// Optional feature: define CLKS_ALOT_DRIFT_CHECK_EN to flag same-phase drift
// beyond acceptable_skew_i; without it drift_o is tied low.

module clks_alot_half_rate_tracker #(
   parameter int RATE_W = 32,
   parameter int LOCK_W = 8,
   parameter int SKEW_W = 8
) (
   input  logic              clk_i,
   input  logic              rst_n_i,
   input  logic              rising_edge_i,
   input  logic              falling_edge_i,
   input  logic              even_50_50_en_i,
   input  logic              lockin_en_i,
   input  logic              pausable_en_i,
   input  logic [RATE_W-1:0] hi_min_m1_i,
   input  logic [RATE_W-1:0] hi_max_m1_i,
   input  logic [RATE_W-1:0] lo_min_m1_i,
   input  logic [RATE_W-1:0] lo_max_m1_i,
   input  logic [LOCK_W-1:0] lockin_rate_i,
   input  logic [RATE_W-1:0] timeout_m1_i,
   input  logic [SKEW_W-1:0] acceptable_skew_i,
   output logic [RATE_W-1:0] high_rate_o,
   output logic [RATE_W-1:0] low_rate_o,
   output logic              rate_valid_o,
   output logic              over_freq_o,
   output logic              under_freq_o,
   output logic              drift_o,
   output logic              locked_o,
   output logic              pause_active_o,
   output logic [RATE_W-1:0] pause_duration_o
);

   typedef enum logic [1:0] {
      ST_ARM,
      ST_TRACK,
      ST_PAUSE
   } state_t;

   localparam logic [RATE_W-1:0] RATE_ONES = '1;
   localparam logic [LOCK_W-1:0] LOCK_ONES = '1;

   state_t            state;
   state_t            state_nxt;
   logic [RATE_W-1:0] cnt;
   logic [RATE_W-1:0] cnt_nxt;
   logic [RATE_W:0]   period_cnt;
   logic [RATE_W:0]   period_nxt;
   logic [LOCK_W-1:0] lock_cnt;
   logic [LOCK_W-1:0] lock_cnt_nxt;
   logic [RATE_W-1:0] high_nxt;
   logic [RATE_W-1:0] low_nxt;
   logic [RATE_W-1:0] dur_nxt;
   logic              valid_nxt;
   logic              over_nxt;
   logic              under_nxt;
   logic              drift_nxt;
   logic              locked_nxt;
   logic              pause_nxt;

   logic              any_edge;
   logic              both_edges;
   logic              cap_high;
   logic [RATE_W-1:0] band_min;
   logic [RATE_W-1:0] band_max;
   logic [RATE_W:0]   period_reload;
   logic [LOCK_W-1:0] lock_target;
   logic [LOCK_W-1:0] lock_inc;
   logic              drift_hit;

   assign any_edge   = rising_edge_i | falling_edge_i;
   assign both_edges = rising_edge_i & falling_edge_i;
   // A falling edge closes a high phase; a rising edge closes a low phase.
   assign cap_high   = falling_edge_i;

   // Even-duty mode judges both phases against the high band.
   assign band_min = (cap_high | even_50_50_en_i) ? hi_min_m1_i : lo_min_m1_i;
   assign band_max = (cap_high | even_50_50_en_i) ? hi_max_m1_i : lo_max_m1_i;

   // One recovered period is (high+1)+(low+1) clocks, i.e. a countdown from
   // high+low+1 to zero. With no rates known yet every clock counts.
   assign period_reload = (high_rate_o == '0 && low_rate_o == '0) ? '0 :
                          ({1'b0, high_rate_o} + {1'b0, low_rate_o} + 1'b1);

   assign lock_target = (lockin_rate_i == '0) ? LOCK_W'(1) : lockin_rate_i;
   assign lock_inc    = (lock_cnt == LOCK_ONES) ? lock_cnt : lock_cnt + 1'b1;

`ifdef CLKS_ALOT_DRIFT_CHECK_EN
   logic              seen_high;
   logic              seen_low;
   logic [RATE_W-1:0] prev_rate;
   logic [RATE_W-1:0] skew_delta;

   assign prev_rate  = cap_high ? high_rate_o : low_rate_o;
   assign skew_delta = (cnt >= prev_rate) ? (cnt - prev_rate) : (prev_rate - cnt);
   // Only compare against a rate captured for this phase since the last ARM.
   assign drift_hit  = (cap_high ? seen_high : seen_low) &&
                       (skew_delta > RATE_W'(acceptable_skew_i));

   // Track which phases hold a rate measured in the current tracking run
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         seen_high <= 1'b0;
         seen_low  <= 1'b0;
      end else if (state_nxt == ST_ARM) begin
         seen_high <= 1'b0;
         seen_low  <= 1'b0;
      end else if (valid_nxt) begin
         if (cap_high) seen_high <= 1'b1;
         else          seen_low  <= 1'b1;
      end
   end

   // Register the drift pulse alongside the other violation pulses
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) drift_o <= 1'b0;
      else          drift_o <= drift_nxt;
   end
`else
   logic unused_cfg;

   assign drift_hit  = 1'b0;
   assign drift_o    = 1'b0;
   assign unused_cfg = ^{acceptable_skew_i, drift_nxt};
`endif

   // Next-state, capture, lock and pause decisions for the current clock
   always_comb begin
      // NOTE: every signal driven here gets a default first, so no path can infer a latch.
      state_nxt    = state;
      cnt_nxt      = any_edge ? '0 : ((cnt == RATE_ONES) ? cnt : cnt + 1'b1);
      period_nxt   = period_cnt;
      lock_cnt_nxt = lock_cnt;
      high_nxt     = high_rate_o;
      low_nxt      = low_rate_o;
      dur_nxt      = pause_duration_o;
      valid_nxt    = 1'b0;
      over_nxt     = 1'b0;
      under_nxt    = 1'b0;
      drift_nxt    = 1'b0;
      locked_nxt   = locked_o;
      pause_nxt    = pause_active_o;

      if (both_edges) begin
         // Contradictory edge report: flag it and re-acquire phase from scratch.
         over_nxt     = 1'b1;
         lock_cnt_nxt = '0;
         locked_nxt   = 1'b0;
         pause_nxt    = 1'b0;
         state_nxt    = ST_ARM;
      end else begin
         case (state)
            ST_ARM: begin
               // Phase start is unknown, so the first edge only aligns.
               if (any_edge) state_nxt = ST_TRACK;
            end
            ST_TRACK: begin
               if (any_edge) begin
                  if (cnt < band_min) begin
                     over_nxt     = 1'b1;
                     lock_cnt_nxt = '0;
                     locked_nxt   = 1'b0;
                  end else if (cnt > band_max) begin
                     under_nxt    = 1'b1;
                     lock_cnt_nxt = '0;
                     locked_nxt   = 1'b0;
                  end else begin
                     valid_nxt = 1'b1;
                     if (cap_high) high_nxt = cnt;
                     else          low_nxt  = cnt;
                     if (drift_hit) begin
                        drift_nxt    = 1'b1;
                        lock_cnt_nxt = '0;
                     end else begin
                        lock_cnt_nxt = lock_inc;
                     end
                     locked_nxt = lockin_en_i ? (lock_cnt_nxt >= lock_target) : 1'b1;
                  end
               end else if (cnt == timeout_m1_i) begin
                  if (pausable_en_i) begin
                     state_nxt  = ST_PAUSE;
                     pause_nxt  = 1'b1;
                     dur_nxt    = '0;
                     period_nxt = period_reload;
                  end else begin
                     under_nxt    = 1'b1;
                     lock_cnt_nxt = '0;
                     locked_nxt   = 1'b0;
                     state_nxt    = ST_ARM;
                  end
               end
            end
            ST_PAUSE: begin
               if (any_edge) begin
                  // Duration is left visible until the next pause begins.
                  pause_nxt = 1'b0;
                  state_nxt = ST_ARM;
               end else if (period_cnt == '0) begin
                  period_nxt = period_reload;
                  if (pause_duration_o != RATE_ONES) dur_nxt = pause_duration_o + 1'b1;
               end else begin
                  period_nxt = period_cnt - 1'b1;
               end
            end
            default: state_nxt = ST_ARM;
         endcase
      end
   end

   // FSM state register
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      if (!rst_n_i) state <= ST_ARM;
      else          state <= state_nxt;
   end

   // Counters and registered outputs
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         cnt              <= '0;
         period_cnt       <= '0;
         lock_cnt         <= '0;
         high_rate_o      <= '0;
         low_rate_o       <= '0;
         rate_valid_o     <= 1'b0;
         over_freq_o      <= 1'b0;
         under_freq_o     <= 1'b0;
         locked_o         <= 1'b0;
         pause_active_o   <= 1'b0;
         pause_duration_o <= '0;
      end else begin
         cnt              <= cnt_nxt;
         period_cnt       <= period_nxt;
         lock_cnt         <= lock_cnt_nxt;
         high_rate_o      <= high_nxt;
         low_rate_o       <= low_nxt;
         rate_valid_o     <= valid_nxt;
         over_freq_o      <= over_nxt;
         under_freq_o     <= under_nxt;
         locked_o         <= locked_nxt;
         pause_active_o   <= pause_nxt;
         pause_duration_o <= dur_nxt;
      end
   end

endmodule

// File: tb/tb_clks_alot_half_rate_tracker.sv
// tb_clks_alot_half_rate_tracker
// Drives edge pulses at chosen gaps and compares every cycle against an
// event-level model: captures are the elapsed clocks since the previous edge,
// pause duration is derived arithmetically from the pause entry time.

module tb_clks_alot_half_rate_tracker;

   localparam int M_ARM   = 0;
   localparam int M_TRACK = 1;
   localparam int M_PAUSE = 2;

   logic        clk_i = 1'b0;
   logic        rst_n_i;
   logic        rising_edge_i;
   logic        falling_edge_i;
   logic        even_50_50_en_i;
   logic        lockin_en_i;
   logic        pausable_en_i;
   logic [31:0] hi_min_m1_i;
   logic [31:0] hi_max_m1_i;
   logic [31:0] lo_min_m1_i;
   logic [31:0] lo_max_m1_i;
   logic [7:0]  lockin_rate_i;
   logic [31:0] timeout_m1_i;
   logic [7:0]  acceptable_skew_i;
   logic [31:0] high_rate_o;
   logic [31:0] low_rate_o;
   logic        rate_valid_o;
   logic        over_freq_o;
   logic        under_freq_o;
   logic        drift_o;
   logic        locked_o;
   logic        pause_active_o;
   logic [31:0] pause_duration_o;

   clks_alot_half_rate_tracker #(
      .RATE_W(32),
      .LOCK_W(8),
      .SKEW_W(8)
   ) dut (
      .clk_i            (clk_i),
      .rst_n_i          (rst_n_i),
      .rising_edge_i    (rising_edge_i),
      .falling_edge_i   (falling_edge_i),
      .even_50_50_en_i  (even_50_50_en_i),
      .lockin_en_i      (lockin_en_i),
      .pausable_en_i    (pausable_en_i),
      .hi_min_m1_i      (hi_min_m1_i),
      .hi_max_m1_i      (hi_max_m1_i),
      .lo_min_m1_i      (lo_min_m1_i),
      .lo_max_m1_i      (lo_max_m1_i),
      .lockin_rate_i    (lockin_rate_i),
      .timeout_m1_i     (timeout_m1_i),
      .acceptable_skew_i(acceptable_skew_i),
      .high_rate_o      (high_rate_o),
      .low_rate_o       (low_rate_o),
      .rate_valid_o     (rate_valid_o),
      .over_freq_o      (over_freq_o),
      .under_freq_o     (under_freq_o),
      .drift_o          (drift_o),
      .locked_o         (locked_o),
      .pause_active_o   (pause_active_o),
      .pause_duration_o (pause_duration_o)
   );

   always #5 clk_i = ~clk_i;

   int checks   = 0;
   int failures = 0;

   // Reference model state
   int          mode;
   logic [31:0] m_hi, m_lo, m_dur, el;
   int          m_lock;
   bit          m_locked, m_pause, seen_hi, seen_lo, next_rise;
   longint      tcyc, m_tent, m_period;
   bit          e_valid, e_over, e_under, e_drift;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: observed %0d expected %0d at t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      mode      = M_ARM;
      m_hi      = '0;
      m_lo      = '0;
      m_dur     = '0;
      el        = '0;
      m_lock    = 0;
      m_locked  = 1'b0;
      m_pause   = 1'b0;
      seen_hi   = 1'b0;
      seen_lo   = 1'b0;
      next_rise = 1'b1;
   endtask

   task automatic to_arm();
      mode    = M_ARM;
      seen_hi = 1'b0;
      seen_lo = 1'b0;
   endtask

   task automatic violate();
      m_lock   = 0;
      m_locked = 1'b0;
   endtask

   // Judge one half-period of 'cap' clocks (minus one) for the given phase
   task automatic measure(input logic [31:0] cap, input bit is_high);
      logic [31:0] mn, mx;
      bit          use_hi;
      use_hi = is_high || even_50_50_en_i;
      mn     = use_hi ? hi_min_m1_i : lo_min_m1_i;
      mx     = use_hi ? hi_max_m1_i : lo_max_m1_i;
      if (cap < mn) begin
         e_over = 1'b1;
         violate();
      end else if (cap > mx) begin
         e_under = 1'b1;
         violate();
      end else begin
         e_valid = 1'b1;
`ifdef CLKS_ALOT_DRIFT_CHECK_EN
         begin
            logic [31:0] prev, diff;
            prev = is_high ? m_hi : m_lo;
            diff = (cap > prev) ? cap - prev : prev - cap;
            if ((is_high ? seen_hi : seen_lo) && diff > 32'(acceptable_skew_i)) begin
               e_drift = 1'b1;
               m_lock  = 0;
            end else begin
               m_lock = (m_lock < 255) ? m_lock + 1 : 255;
            end
         end
`else
         m_lock = (m_lock < 255) ? m_lock + 1 : 255;
`endif
         if (is_high) begin
            m_hi    = cap;
            seen_hi = 1'b1;
         end else begin
            m_lo    = cap;
            seen_lo = 1'b1;
         end
         m_locked = lockin_en_i ? (m_lock >= ((lockin_rate_i == 8'd0) ? 1 : int'(lockin_rate_i))) : 1'b1;
      end
   endtask

   // One clock with the given edge inputs; predicts and checks all outputs
   task automatic cyc(input bit r, input bit f);
      longint c;
      c       = tcyc;
      e_valid = 1'b0;
      e_over  = 1'b0;
      e_under = 1'b0;
      e_drift = 1'b0;
      if (r || f) begin
         if (r && f) begin
            e_over  = 1'b1;
            violate();
            m_pause = 1'b0;
            to_arm();
         end else if (mode == M_ARM) begin
            mode = M_TRACK;
         end else if (mode == M_PAUSE) begin
            m_pause = 1'b0;
            to_arm();
         end else begin
            measure(el, f);
         end
         el = '0;
      end else begin
         if (mode == M_TRACK && el == timeout_m1_i) begin
            if (pausable_en_i) begin
               mode     = M_PAUSE;
               m_pause  = 1'b1;
               m_tent   = c;
               m_period = (m_hi == 0 && m_lo == 0) ? 64'd1 :
                          longint'(m_hi) + longint'(m_lo) + 64'd2;
            end else begin
               e_under = 1'b1;
               violate();
               to_arm();
            end
         end
         if (el != 32'hFFFF_FFFF) el = el + 32'd1;
      end
      if (mode == M_PAUSE) m_dur = 32'((c - m_tent) / m_period);
      rising_edge_i  = r;
      falling_edge_i = f;
      @(negedge clk_i);
      tcyc++;
      check("pulses", 64'({rate_valid_o, over_freq_o, under_freq_o, drift_o}),
            64'({e_valid, e_over, e_under, e_drift}));
      check("rates", {high_rate_o, low_rate_o}, {m_hi, m_lo});
      check("status", 64'({locked_o, pause_active_o}), 64'({m_locked, m_pause}));
      check("pause_dur", 64'(pause_duration_o), 64'(m_dur));
      rising_edge_i  = 1'b0;
      falling_edge_i = 1'b0;
   endtask

   // Half-period of g clocks ending in the alternating edge
   task automatic half(input int g);
      for (int i = 1; i < g; i++) cyc(1'b0, 1'b0);
      cyc(next_rise, !next_rise);
      next_rise = !next_rise;
   endtask

   // g clocks ending in an arbitrary edge pattern, phase tracking untouched
   task automatic edge_after(input int g, input bit r, input bit f);
      for (int i = 1; i < g; i++) cyc(1'b0, 1'b0);
      cyc(r, f);
   endtask

   task automatic set_band(input int mn, input int mx);
      hi_min_m1_i = 32'(mn);
      hi_max_m1_i = 32'(mx);
      lo_min_m1_i = 32'(mn);
      lo_max_m1_i = 32'(mx);
   endtask

   task automatic check_reset_values();
      check("reset_rates", {high_rate_o, low_rate_o}, 64'd0);
      check("reset_flags", 64'({rate_valid_o, over_freq_o, under_freq_o, drift_o,
                                locked_o, pause_active_o}), 64'd0);
      check("reset_dur", 64'(pause_duration_o), 64'd0);
   endtask

   task automatic randomize_cfg();
      hi_min_m1_i       = $urandom_range(0, 8);
      hi_max_m1_i       = hi_min_m1_i + $urandom_range(0, 8);
      lo_min_m1_i       = $urandom_range(0, 8);
      lo_max_m1_i       = lo_min_m1_i + $urandom_range(0, 8);
      even_50_50_en_i   = 1'($urandom_range(0, 1));
      lockin_en_i       = 1'($urandom_range(0, 1));
      pausable_en_i     = 1'($urandom_range(0, 1));
      lockin_rate_i     = 8'($urandom_range(0, 6));
      timeout_m1_i      = $urandom_range(10, 40);
      acceptable_skew_i = 8'($urandom_range(0, 3));
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int unders;
      int g, k;
      rst_n_i           = 1'b0;
      rising_edge_i     = 1'b0;
      falling_edge_i    = 1'b0;
      even_50_50_en_i   = 1'b0;
      lockin_en_i       = 1'b1;
      pausable_en_i     = 1'b0;
      set_band(3, 5);
      lockin_rate_i     = 8'd4;
      timeout_m1_i      = 32'd1000;
      acceptable_skew_i = 8'd1;
      tcyc              = 0;
      m_tent            = 0;
      m_period          = 1;
      model_reset();

      repeat (3) @(negedge clk_i);
      check_reset_values();
      rst_n_i = 1'b1;

      // Edges every 5 clocks, band 3..5, lock after 4 captures
      half(5);
      repeat (3) half(5);
      check("not_locked_after_3", 64'(locked_o), 64'd0);
      half(5);
      check("locked_after_4", 64'(locked_o), 64'd1);
      repeat (6) half(5);
      check("high_rate_4", 64'(high_rate_o), 64'd4);
      check("low_rate_4", 64'(low_rate_o), 64'd4);

      // Short half-period breaks lock, rates hold, relock after 4 good ones
      half(2);
      check("short_over", 64'(over_freq_o), 64'd1);
      check("short_unlock", 64'(locked_o), 64'd0);
      repeat (4) half(5);
      check("relock", 64'(locked_o), 64'd1);

      // Band edges: min and max accepted, one beyond each rejected
      half(4);
      half(6);
      half(7);
      check("above_max_under", 64'(under_freq_o), 64'd1);
      half(3);
      check("below_min_over", 64'(over_freq_o), 64'd1);

      // Simultaneous edges
      edge_after(5, 1'b1, 1'b1);
      check("both_over", 64'(over_freq_o), 64'd1);
      check("both_no_valid", 64'(rate_valid_o), 64'd0);
      half(5);
      check("arm_not_measured", 64'(rate_valid_o), 64'd0);

      // Non-pausable timeout
      timeout_m1_i = 32'd20;
      unders = 0;
      for (int i = 0; i < 40; i++) begin
         cyc(1'b0, 1'b0);
         if (under_freq_o) unders++;
      end
      check("timeout_one_under", 64'(unders), 64'd1);
      half(5);
      check("after_timeout_not_measured", 64'(rate_valid_o), 64'd0);

      // Pausable timeout with rates 4/4
      pausable_en_i = 1'b1;
      half(5);
      half(5);
      repeat (81) cyc(1'b0, 1'b0);
      check("pause_active", 64'(pause_active_o), 64'd1);
      check("pause_dur_6", 64'(pause_duration_o), 64'd6);
      half(5);
      check("pause_exit", 64'(pause_active_o), 64'd0);
      check("pause_dur_held", 64'(pause_duration_o), 64'd6);
      half(5);
      repeat (21) cyc(1'b0, 1'b0);
      check("pause_reentry", 64'(pause_active_o), 64'd1);
      check("pause_dur_cleared", 64'(pause_duration_o), 64'd0);
      half(5);

`ifdef CLKS_ALOT_DRIFT_CHECK_EN
      // High rate 4 then 6 with skew 1 is drift
      pausable_en_i     = 1'b0;
      timeout_m1_i      = 32'd1000;
      acceptable_skew_i = 8'd1;
      set_band(3, 7);
      half(5);
      repeat (4) half(5);
      if (next_rise) half(5);
      half(7);
      check("drift_pulse", 64'(drift_o), 64'd1);
      check("drift_rate_updates", 64'(high_rate_o), 64'd6);
      check("drift_unlock", 64'(locked_o), 64'd0);
`endif

      // Reset in the middle of a measurement
      repeat (3) cyc(1'b0, 1'b0);
      rst_n_i = 1'b0;
      @(negedge clk_i);
      check_reset_values();
      model_reset();
      rst_n_i = 1'b1;

      // Randomized edges and configuration
      randomize_cfg();
      for (int n = 0; n < 400; n++) begin
         if ($urandom_range(0, 7) == 0) randomize_cfg();
         g = $urandom_range(1, 30);
         k = $urandom_range(0, 19);
         if (k == 0)      edge_after(g, 1'b1, 1'b1);
         else if (k == 1) edge_after(g, !next_rise, next_rise);
         else             half(g);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
